// File: rtl/alu_secuenciador.sv
// Two-requester, round-robin sequencer that serialises operations onto a shared
// registered ALU and returns each result tagged with the id of its requester.
//
// state | meaning
// IDLE  | arbitrating; the granted requester sees ready and is accepted on the next edge
// EXEC  | operands held on alu_*, counting down the ALU latency
// RESP  | result held on rsp_*, waiting for rsp_ready
module alu_secuenciador #(
   parameter int DATA_WIDTH  = 8,
   parameter int ALU_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req0_valid,
   output logic                      req0_ready,
   input  logic [2:0]                req0_opcode,
   input  logic [DATA_WIDTH-1:0]     req0_a,
   input  logic [DATA_WIDTH-1:0]     req0_b,
   input  logic                      req1_valid,
   output logic                      req1_ready,
   input  logic [2:0]                req1_opcode,
   input  logic [DATA_WIDTH-1:0]     req1_a,
   input  logic [DATA_WIDTH-1:0]     req1_b,
   output logic [2:0]                alu_opcode,
   output logic [DATA_WIDTH-1:0]     alu_a,
   output logic [DATA_WIDTH-1:0]     alu_b,
   input  logic [2*DATA_WIDTH-1:0]   alu_data,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_id,
   output logic [2*DATA_WIDTH-1:0]   rsp_data,
   output logic                      busy
);

   localparam int CW = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state;
   logic            last;
   logic [CW-1:0]   cnt;
   logic            any_valid;
   logic            grant;

   // On contention the requester that did not win last time gets the slot.
   always_comb begin
      any_valid = req0_valid | req1_valid;
      grant     = (req0_valid && req1_valid) ? ~last : req1_valid;
   end

   assign req0_ready = (state == IDLE) && any_valid && !grant && !rst;
   assign req1_ready = (state == IDLE) && any_valid &&  grant && !rst;
   assign rsp_valid  = (state == RESP);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last       <= 1'b1;
         cnt        <= '0;
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  alu_opcode <= grant ? req1_opcode : req0_opcode;
                  alu_a      <= grant ? req1_a      : req0_a;
                  alu_b      <= grant ? req1_b      : req0_b;
                  rsp_id     <= grant;
                  last       <= grant;
                  cnt        <= CW'(ALU_LATENCY);
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  rsp_data <= alu_data;
                  state    <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_secuenciador.sv
// Directed bench for alu_secuenciador with a one-cycle registered ALU model.
module tb_alu_secuenciador;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [2:0]  req0_opcode, req1_opcode;
   logic [7:0]  req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  alu_opcode;
   logic [7:0]  alu_a, alu_b;
   logic [15:0] alu_data;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [15:0] rsp_data;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_secuenciador #(.DATA_WIDTH(8), .ALU_LATENCY(1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_data(alu_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .busy(busy)
   );

   function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
      logic [8:0] s9;
      case (op)
         3'b000:  begin s9 = {1'b0, a} + {1'b0, b}; return {{7{s9[8]}}, s9}; end
         3'b001:  begin s9 = {1'b0, a} - {1'b0, b}; return {{7{s9[8]}}, s9}; end
         3'b010:  return 16'(a) * 16'(b);
         3'b011:  return {8'h00, a & b};
         3'b100:  return {8'h00, a | b};
         3'b101:  return {8'h00, ~(a & b)};
         3'b110:  return {8'h00, ~(a | b)};
         default: return {8'h00, a ^ b};
      endcase
   endfunction

   always_ff @(posedge clk) alu_data <= alu_fn(alu_opcode, alu_a, alu_b);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 20) begin
         @(posedge clk); #2;
         n++;
      end
      check("idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      int acc_id[$];
      int acc_cyc[$];
      int cyc;
      int n;
      logic seen;

      rst = 1'b1;
      req0_valid = 1'b1; req0_opcode = 3'b000; req0_a = 8'h00; req0_b = 8'h00;
      req1_valid = 1'b0; req1_opcode = 3'b000; req1_a = 8'h00; req1_b = 8'h00;
      rsp_ready  = 1'b0;

      // Reset held for two cycles with req0 pending
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #2;
         check("rst_req0_ready", 32'(req0_ready), 32'd0);
         check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_alu", {8'(alu_opcode), alu_a, alu_b, 8'h0}, 32'd0);
         check("rst_rsp", {15'd0, rsp_id, rsp_data}, 32'd0);
      end

      // Single sum from req0: 7F + 01 -> 0080
      @(posedge clk); #1;
      rst = 1'b0;
      req0_opcode = 3'b000; req0_a = 8'h7F; req0_b = 8'h01;
      #1;
      check("sum_req0_ready", 32'(req0_ready), 32'd1);
      check("sum_req1_ready", 32'(req1_ready), 32'd0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      #1;
      check("sum_busy", 32'(busy), 32'd1);
      check("sum_alu", {8'(alu_opcode), alu_a, alu_b, 8'h0}, {8'h00, 8'h7F, 8'h01, 8'h0});
      check("sum_rsp_valid_k0", 32'(rsp_valid), 32'd0);
      @(posedge clk); #2;
      check("sum_rsp_valid_k1", 32'(rsp_valid), 32'd0);
      @(posedge clk); #2;
      check("sum_rsp_valid_k2", 32'(rsp_valid), 32'd1);
      check("sum_rsp_data", 32'(rsp_data), 32'h0080);
      check("sum_rsp_id", 32'(rsp_id), 32'd0);
      rsp_ready = 1'b1;
      @(posedge clk); #2;
      check("sum_back_idle", 32'(busy), 32'd0);
      check("sum_rsp_drop", 32'(rsp_valid), 32'd0);
      rsp_ready = 1'b0;

      // Multiply from req1: FF * FF -> FE01, operands stable through EXEC
      req1_valid = 1'b1; req1_opcode = 3'b010; req1_a = 8'hFF; req1_b = 8'hFF;
      #1;
      check("mul_req1_ready", 32'(req1_ready), 32'd1);
      check("mul_req0_ready", 32'(req0_ready), 32'd0);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      #1;
      check("mul_alu_k0", {8'(alu_opcode), alu_a, alu_b, 8'h0}, {8'h02, 8'hFF, 8'hFF, 8'h0});
      @(posedge clk); #2;
      check("mul_alu_k1", {8'(alu_opcode), alu_a, alu_b, 8'h0}, {8'h02, 8'hFF, 8'hFF, 8'h0});
      check("mul_rsp_valid_k1", 32'(rsp_valid), 32'd0);
      @(posedge clk); #2;
      check("mul_rsp_valid_k2", 32'(rsp_valid), 32'd1);
      check("mul_rsp_data", 32'(rsp_data), 32'hFE01);
      check("mul_rsp_id", 32'(rsp_id), 32'd1);

      // Back-pressure: response frozen and no grants while both requesters wait
      req0_valid = 1'b1; req0_opcode = 3'b000; req0_a = 8'h03; req0_b = 8'h04;
      req1_valid = 1'b1; req1_opcode = 3'b100; req1_a = 8'hF0; req1_b = 8'h0F;
      #1;
      for (int i = 0; i < 10; i++) begin
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp", {15'd0, rsp_id, rsp_data}, {15'd0, 1'b1, 16'hFE01});
         check("bp_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
         @(posedge clk); #2;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #2;
      check("bp_release_idle", 32'(busy), 32'd0);

      // Contention: grants alternate 0,1,0,1 four cycles apart
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      cyc = 0;
      while (acc_id.size() < 4 && cyc < 40) begin
         check("cont_one_ready", 32'(req0_ready && req1_ready), 32'd0);
         if (req0_ready) begin acc_id.push_back(0); acc_cyc.push_back(cyc); end
         if (req1_ready) begin acc_id.push_back(1); acc_cyc.push_back(cyc); end
         if (rsp_valid)
            check("cont_rsp_data", 32'(rsp_data), rsp_id ? 32'h00FF : 32'h0007);
         @(posedge clk); #2;
         cyc++;
      end
      check("cont_accepts", 32'(acc_id.size()), 32'd4);
      if (acc_id.size() == 4) begin
         for (int i = 0; i < 4; i++) check("cont_grant", 32'(acc_id[i]), 32'(i % 2));
         for (int i = 1; i < 4; i++) check("cont_interval", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_idle();

      // Reset one cycle after accepting req0 xor AA^55: operation discarded
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_opcode = 3'b111; req0_a = 8'hAA; req0_b = 8'h55;
      #1;
      check("xor_req0_ready", 32'(req0_ready), 32'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_alu", {8'(alu_opcode), alu_a, alu_b, 8'h0}, 32'd0);
      check("mid_rst_rsp", {14'd0, rsp_valid, rsp_id, rsp_data}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #2;
         seen = seen | rsp_valid;
      end
      check("mid_rst_no_rsp", 32'(seen), 32'd0);

      // First contention after reset goes to req0: 05 - 07 -> FFFE
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_opcode = 3'b001; req0_a = 8'h05; req0_b = 8'h07;
      req1_valid = 1'b1; req1_opcode = 3'b101; req1_a = 8'h0F; req1_b = 8'h3C;
      #1;
      check("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      n = 0;
      while (!rsp_valid && n < 10) begin
         @(posedge clk); #2;
         n++;
      end
      check("post_rst_rsp_wait", 32'(rsp_valid), 32'd1);
      check("post_rst_rsp", {15'd0, rsp_id, rsp_data}, {15'd0, 1'b0, 16'hFFFE});
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
